// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: formats stores, extracts and extends loads,
// runs the dmem request/grant/response handshake, and bounds every wait with a timeout.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic        ex_mem_load,
    input  logic        ex_mem_store,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_alu,
    input  logic [31:0] ex_mem_store_data,
    output logic        ex_mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_data,
    output logic        mem_wb_fault
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;

    // Counter value in the last cycle the unit may still wait for the awaited event.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic access_legal(input logic ld, input logic st,
                                          input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lane[0];
            3'b010:  ok = (lane == 2'b00);
            3'b100:  ok = ~st;
            3'b101:  ok = ~st & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok & ~(ld & st);
    endfunction

    function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] lane,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_fault_q, wb_fault_d;

    // Next-state, bus and write-back computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_fault_d   = wb_fault_q;

        case (state_q)
            S_IDLE: begin
                if (!ex_mem_valid) begin
                    state_d = S_IDLE;
                end else if (!ex_mem_load && !ex_mem_store) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_mem_alu;
                    wb_fault_d = 1'b0;
                end else if (!access_legal(ex_mem_load, ex_mem_store, ex_mem_funct3, ex_mem_alu[1:0])) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = 32'd0;
                    wb_fault_d = 1'b1;
                end else begin
                    state_d      = S_REQ;
                    cnt_d        = 8'd0;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = ex_mem_store;
                    dmem_addr_d  = {ex_mem_alu[31:2], 2'b00};
                    dmem_be_d    = access_be(ex_mem_funct3, ex_mem_alu[1:0]);
                    dmem_wdata_d = ex_mem_store ? store_wdata(ex_mem_funct3, ex_mem_store_data) : 32'd0;
                    lane_d       = ex_mem_alu[1:0];
                    funct3_d     = ex_mem_funct3;
                end
            end
            S_REQ: begin
                // The grant is checked before the timeout so a last-cycle grant still completes.
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    cnt_d      = 8'd0;
                    if (dmem_we_q) begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = 32'd0;
                        wb_fault_d = 1'b0;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = 32'd0;
                    wb_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_R: begin
                if (dmem_rvalid) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = load_extract(dmem_rdata, lane_q, funct3_q);
                    wb_fault_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = 32'd0;
                    wb_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            lane_q       <= 2'd0;
            funct3_q     <= 3'd0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= 32'd0;
            wb_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_fault_q   <= wb_fault_d;
        end
    end

    assign ex_mem_stall = (state_q != S_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign mem_wb_valid = wb_valid_q;
    assign mem_wb_data  = wb_data_q;
    assign mem_wb_fault = wb_fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, randomized operations
// against an arithmetic reference model, and hand-written reset/timeout sequences.
module tb_mem_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_valid, ex_mem_load, ex_mem_store;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_alu, ex_mem_store_data;
    logic        ex_mem_stall;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_data;
    logic        mem_wb_fault;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .ex_mem_valid(ex_mem_valid), .ex_mem_load(ex_mem_load), .ex_mem_store(ex_mem_store),
        .ex_mem_funct3(ex_mem_funct3), .ex_mem_alu(ex_mem_alu), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_stall(ex_mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_wb_valid(mem_wb_valid), .mem_wb_data(mem_wb_data), .mem_wb_fault(mem_wb_fault)
    );

    // g = cycle of REQ in which the grant arrives (g > T: never); r = cycles after grant until rvalid.
    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rd;
        int          g;
        int          r;
        logic        bus;
        logic        fault;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_fault = 1'b0;
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: result of one instruction from the access rules, using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          size;
        int          lane;
        bit          ok;
        longint unsigned val;
        e = v;
        e.bus = 1'b0; e.fault = 1'b0; e.data = 32'd0; e.be = 4'd0; e.wdata = 32'd0;
        if (!v.ld && !v.st) begin
            e.data = v.alu;
            return e;
        end
        case (v.f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        lane = int'(v.alu[1:0]);
        ok = 1'b0;
        if (size != 0 && !(v.ld && v.st) && !(v.st && v.f3[2]))
            ok = ((lane % size) == 0);
        if (!ok) begin
            e.fault = 1'b1;
            return e;
        end
        e.bus = 1'b1;
        e.be  = 4'(((1 << size) - 1) << lane);
        if (v.st) begin
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = v.sd[8*(i % size) +: 8];
        end else begin
            val = (64'(v.rd) >> (8 * lane)) & ((64'd1 << (8 * size)) - 64'd1);
            if (!v.f3[2] && size < 4 && val >= (64'd1 << (8 * size - 1)))
                val = val - (64'd1 << (8 * size));
            e.data = val[31:0];
        end
        if (v.g > T) begin
            e.fault = 1'b1;
            e.data  = 32'd0;
        end
        return e;
    endfunction

    task automatic idle_inputs();
        ex_mem_valid = 1'b0; ex_mem_load = 1'b0; ex_mem_store = 1'b0; ex_mem_funct3 = 3'd0;
        ex_mem_alu = 32'd0; ex_mem_store_data = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    // Issue one instruction from IDLE and check every cycle until it has retired.
    task automatic do_op(input vec_t v);
        int wb_c;
        int req_len;
        ex_mem_valid = 1'b1; ex_mem_load = v.ld; ex_mem_store = v.st; ex_mem_funct3 = v.f3;
        ex_mem_alu = v.alu; ex_mem_store_data = v.sd;
        if (!v.bus) begin
            req_len = 0; wb_c = 1;
        end else if (v.g > T) begin
            req_len = T; wb_c = T + 1;
        end else begin
            req_len = v.g; wb_c = v.st ? v.g + 1 : v.g + v.r + 1;
        end
        @(posedge clk); #1;
        for (int c = 1; c <= wb_c + 1; c++) begin
            // Stray valid while stalled must be ignored.
            ex_mem_valid = (c < wb_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            ex_mem_load = 1'b0; ex_mem_store = 1'b0; ex_mem_alu = $urandom;
            dmem_gnt = (c == v.g && v.g <= T) ||
                       (c > req_len && c < wb_c && $urandom_range(0, 1) == 1);
            dmem_rvalid = (v.bus && v.ld && v.g <= T && c == v.g + v.r) ||
                          ((c <= req_len || c >= wb_c) && $urandom_range(0, 1) == 1);
            dmem_rdata = (c == v.g + v.r) ? v.rd : $urandom;
            check({v.name, ".req"},   32'(dmem_req),     32'(c <= req_len));
            check({v.name, ".stall"}, 32'(ex_mem_stall), 32'(c < wb_c));
            check({v.name, ".valid"}, 32'(mem_wb_valid), 32'(c == wb_c));
            if (c <= req_len) begin
                check({v.name, ".addr"},  dmem_addr,       v.alu & 32'hFFFF_FFFC);
                check({v.name, ".we"},    32'(dmem_we),    32'(v.st));
                check({v.name, ".be"},    32'(dmem_be),    32'(v.be));
                check({v.name, ".wdata"}, dmem_wdata,      v.wdata);
            end
            if (c >= wb_c) begin
                check({v.name, ".data"},  mem_wb_data,       v.data);
                check({v.name, ".fault"}, 32'(mem_wb_fault), 32'(v.fault));
            end else begin
                check({v.name, ".hold_data"},  mem_wb_data,       prev_data);
                check({v.name, ".hold_fault"}, 32'(mem_wb_fault), 32'(prev_fault));
            end
            @(posedge clk); #1;
        end
        prev_data = v.data;
        prev_fault = v.fault;
        idle_inputs();
    endtask

    initial begin
        vec_t v;
        int   kind;
        bit   seen;
        logic [2:0] f3_list [8];
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req",   32'(dmem_req),     32'd0);
        check("rst.stall", 32'(ex_mem_stall), 32'd0);
        check("rst.valid", 32'(mem_wb_valid), 32'd0);
        check("rst.data",  mem_wb_data,       32'd0);
        check("rst.addr",  dmem_addr,         32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        //            name    ld    st    f3      alu           sd            rd            g  r  bus   fault data          be       wdata
        tbl.push_back('{"alu",  1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        1, 1, 1'b0, 1'b0, 32'h1234_5678, 4'b0000, 32'h0});
        tbl.push_back('{"sb",   1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,       3, 1, 1'b1, 1'b0, 32'h0,         4'b1000, 32'hA5A5_A5A5});
        tbl.push_back('{"lb",   1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_0000, 1, 2, 1'b1, 1'b0, 32'hFFFF_FF80, 4'b0100, 32'h0});
        tbl.push_back('{"lhu",  1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_0000, 2, 1, 1'b1, 1'b0, 32'h0000_8001, 4'b1100, 32'h0});
        tbl.push_back('{"lw",   1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 1, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0});
        tbl.push_back('{"lwmis",1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        1, 1, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0});
        tbl.push_back('{"shmis",1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h1111_2222, 32'h0,       1, 1, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0});
        tbl.push_back('{"f3bad",1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,        1, 1, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0});
        tbl.push_back('{"sbto", 1'b0, 1'b1, 3'b000, 32'h0000_0040, 32'h0000_0011, 32'h0,       9, 1, 1'b1, 1'b1, 32'h0,         4'b0001, 32'h1111_1111});
        tbl.push_back('{"swg4", 1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,       4, 1, 1'b1, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D});
        tbl.push_back('{"ldst", 1'b1, 1'b1, 3'b010, 32'h0000_0048, 32'h0,        32'h0,        1, 1, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0});
        tbl.push_back('{"sh",   1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 32'h0,       1, 1, 1'b1, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF});
        tbl.push_back('{"lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_FF00, 2, 2, 1'b1, 1'b0, 32'h0000_00FF, 4'b0010, 32'h0});
        tbl.push_back('{"sbu",  1'b0, 1'b1, 3'b100, 32'h0000_0004, 32'h0,        32'h0,        1, 1, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0});
        foreach (tbl[i]) do_op(tbl[i]);

        f3_list = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 7));
            v.name = "rand";
            v.ld  = (kind == 1) || (kind >= 2 && kind <= 4);
            v.st  = (kind == 1) || (kind >= 5);
            v.f3  = f3_list[$urandom_range(0, 7)];
            v.alu = $urandom;
            v.sd  = $urandom;
            v.rd  = $urandom;
            v.g   = int'($urandom_range(1, T + 1));
            if (v.ld && !v.st && v.g == T) v.g = T - 1;
            v.r   = (v.g < T) ? int'($urandom_range(1, T - v.g)) : 1;
            do_op(model(v));
        end

        // Reset while waiting for read data; a later rvalid must not retire anything.
        ex_mem_valid = 1'b1; ex_mem_load = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_alu = 32'h0000_0040;
        @(posedge clk); #1;
        idle_inputs();
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check("rstw.stall_before", 32'(ex_mem_stall), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw.req",   32'(dmem_req),     32'd0);
        check("rstw.stall", 32'(ex_mem_stall), 32'd0);
        check("rstw.valid", 32'(mem_wb_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("rstw.valid_after", 32'(mem_wb_valid), 32'd0);
        check("rstw.req_after",   32'(dmem_req),     32'd0);
        check("rstw.stall_after", 32'(ex_mem_stall), 32'd0);
        check("rstw.data_after",  mem_wb_data,       32'd0);
        prev_data = 32'd0; prev_fault = 1'b0;

        // Load granted but never answered: a fault must retire it within a bounded time.
        ex_mem_valid = 1'b1; ex_mem_load = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_alu = 32'h0000_0080;
        @(posedge clk); #1;
        idle_inputs();
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            check("rto.req", 32'(dmem_req), 32'd0);
            if (mem_wb_valid) begin
                seen = 1'b1;
                check("rto.fault", 32'(mem_wb_fault), 32'd1);
                check("rto.data",  mem_wb_data,       32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        check("rto.seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check("rto.stall_end", 32'(ex_mem_stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
